// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed N-digit common-anode seven-segment driver
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int PHASE_CYCLES = 625
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [3:0]              brightness_in,
    input  logic                    load,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(PHASE_CYCLES - 1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   dp;
        logic [3:0]              bright;
    } frame_t;

    localparam frame_t FRAME_RESET = '{digits: '0, blank: '1, dp: '0, bright: 4'd0};

    logic [CW-1:0]         phase_cnt_q, phase_cnt_d;
    logic [3:0]            phase_q, phase_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic                  pending_q, pending_d;
    frame_t                shadow_q, shadow_d;
    frame_t                active_q, active_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  frame_done_q, frame_done_d;

    logic       cnt_wrap, phase_wrap, frame_wrap;
    logic [3:0] cur_hex;
    logic       cur_blank;
    logic       cur_dp;

    function automatic logic [6:0] glyph(input logic [3:0] hex);
        logic [6:0] g;
        case (hex)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    always_comb begin
        cnt_wrap   = (phase_cnt_q == LAST_CNT);
        phase_wrap = cnt_wrap && (phase_q == 4'd15);
        frame_wrap = phase_wrap && (digit_q == LAST_DIGIT);

        phase_cnt_d = cnt_wrap ? '0 : phase_cnt_q + CW'(1);
        phase_d     = cnt_wrap ? phase_q + 4'd1 : phase_q;
        digit_d     = digit_q;
        if (phase_wrap) begin
            digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + DW'(1);
        end

        // Promotion reads the old shadow, so a load on the boundary edge waits one more frame.
        active_d  = (frame_wrap && pending_q) ? shadow_q : active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (frame_wrap && pending_q) begin
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = '{digits: digits_in, blank: blank_in, dp: dp_in, bright: brightness_in};
            pending_d = 1'b1;
        end

        // Outputs are built from next-state values so they track the counters exactly.
        cur_hex   = active_d.digits[4*int'(digit_d) +: 4];
        cur_blank = active_d.blank[digit_d];
        cur_dp    = active_d.dp[digit_d];

        seg_n_d = cur_blank ? 7'b1111111 : glyph(cur_hex);
        dp_n_d  = cur_blank | ~cur_dp;
        an_n_d  = '1;
        if (!cur_blank && (phase_d != 4'd0) && (phase_d <= active_d.bright)) begin
            an_n_d[digit_d] = 1'b0;
        end
        frame_done_d = frame_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt_q  <= '0;
            phase_q      <= 4'd0;
            digit_q      <= '0;
            pending_q    <= 1'b0;
            shadow_q     <= FRAME_RESET;
            active_q     <= FRAME_RESET;
            seg_n_q      <= 7'b1111111;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            frame_done_q <= 1'b0;
        end else begin
            phase_cnt_q  <= phase_cnt_d;
            phase_q      <= phase_d;
            digit_q      <= digit_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - scoreboard bench for seven_segment_scanner
module tb_seven_segment_scanner;

    localparam int ND    = 4;
    localparam int PC    = 2;
    localparam int SLOT  = 16 * PC;
    localparam int FRAME = SLOT * ND;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  blank_in, dp_in, brightness_in;
    logic        load;
    wire  [6:0]  seg_n;
    wire         dp_n;
    wire  [3:0]  an_n;
    wire         frame_done;

    always #5 clk = ~clk;

    seven_segment_scanner #(.NUM_DIGITS(ND), .PHASE_CYCLES(PC)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .blank_in(blank_in),
        .dp_in(dp_in), .brightness_in(brightness_in), .load(load),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t sbq[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;

    logic [15:0] m_cur_dig, m_sh_dig;
    logic [3:0]  m_cur_blank, m_sh_blank, m_cur_dp, m_sh_dp, m_cur_br, m_sh_br;
    bit          m_pend;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] table_g [16];
        table_g = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return table_g[h];
    endfunction

    function automatic exp_t expect_at(int pos);
        exp_t e;
        int   k, ph;
        logic bl;
        k  = pos / SLOT;
        ph = (pos % SLOT) / PC;
        bl = m_cur_blank[k];
        e.seg = bl ? 7'b1111111 : glyph(m_cur_dig[4*k +: 4]);
        e.dp  = bl ? 1'b1 : ~m_cur_dp[k];
        e.an  = 4'hF;
        if (!bl && ph >= 1 && ph <= int'(m_cur_br)) e.an[k] = 1'b0;
        e.fd  = (pos == 0);
        return e;
    endfunction

    task automatic model_reset();
        m_cur_dig = '0; m_sh_dig = '0;
        m_cur_blank = 4'hF; m_sh_blank = 4'hF;
        m_cur_dp = '0; m_sh_dp = '0;
        m_cur_br = '0; m_sh_br = '0;
        m_pend = 0;
        cyc = 0;
        sbq.delete();
    endtask

    // One clock: update the expected frame for this edge, push the expectation, then strobe ends.
    task automatic drive_cycle();
        int pos;
        pos = (cyc + 1) % FRAME;
        if (pos == 0 && m_pend) begin
            m_cur_dig = m_sh_dig; m_cur_blank = m_sh_blank;
            m_cur_dp = m_sh_dp; m_cur_br = m_sh_br;
            m_pend = 0;
        end
        if (load) begin
            m_sh_dig = digits_in; m_sh_blank = blank_in;
            m_sh_dp = dp_in; m_sh_br = brightness_in;
            m_pend = 1;
        end
        sbq.push_back(expect_at(pos));
        @(posedge clk);
        #1;
        cyc++;
        load = 1'b0;
    endtask

    task automatic set_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p,
                            input logic [3:0] br);
        digits_in = d; blank_in = b; dp_in = p; brightness_in = br; load = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e, got;
        rst_n = 1'b0; load = 1'b0;
        digits_in = '0; blank_in = '0; dp_in = '0; brightness_in = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (seg_n !== 7'b1111111) begin tests_failed++; $display("FAIL reset_seg got %b exp 1111111", seg_n); end
        tests_run++;
        if (dp_n !== 1'b1) begin tests_failed++; $display("FAIL reset_dp got %b exp 1", dp_n); end
        tests_run++;
        if (an_n !== 4'hF) begin tests_failed++; $display("FAIL reset_an got %b exp 1111", an_n); end
        tests_run++;
        if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_fd got %b exp 0", frame_done); end
        rst_n = 1'b1;
        model_reset();
        repeat (4 * FRAME) begin
            drive_cycle();
            e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL dark cyc=%0d got %b exp %b", cyc, got, e); end
        end
    endtask

    task automatic test_digits();
        exp_t e, got;
        set_load(16'hA321, 4'b0000, 4'b0100, 4'd15);
        repeat (2 * FRAME) begin
            drive_cycle();
            e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL digits cyc=%0d got %b exp %b", cyc, got, e); end
        end
    endtask

    task automatic test_brightness();
        exp_t e, got;
        int   fstart, lit, first, stray;
        set_load(16'hA321, 4'b0000, 4'b0100, 4'd3);
        fstart = cyc + FRAME; lit = 0; first = -1;
        repeat (2 * FRAME) begin
            drive_cycle();
            e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL bright3 cyc=%0d got %b exp %b", cyc, got, e); end
            if (cyc >= fstart && cyc < fstart + SLOT && an_n[0] === 1'b0) begin
                lit++;
                if (first < 0) first = cyc - fstart;
            end
        end
        tests_run++;
        if (lit != 6) begin tests_failed++; $display("FAIL bright3_lit got %0d exp 6", lit); end
        tests_run++;
        if (first != 2) begin tests_failed++; $display("FAIL bright3_start got %0d exp 2", first); end
        set_load(16'hA321, 4'b0000, 4'b0100, 4'd0);
        fstart = cyc + FRAME; stray = 0;
        repeat (2 * FRAME) begin
            drive_cycle();
            e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL bright0 cyc=%0d got %b exp %b", cyc, got, e); end
            if (cyc >= fstart && cyc < fstart + FRAME && an_n !== 4'hF) stray++;
        end
        tests_run++;
        if (stray != 0) begin tests_failed++; $display("FAIL bright0_dark got %0d lit cycles exp 0", stray); end
    endtask

    task automatic test_glyphs();
        exp_t e, got;
        repeat (10) begin
            drive_cycle();
            e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL midload cyc=%0d got %b exp %b", cyc, got, e); end
        end
        set_load(16'hFFFF, 4'b0000, 4'b0000, 4'd15);
        repeat (FRAME - 10) begin
            drive_cycle();
            e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL midload cyc=%0d got %b exp %b", cyc, got, e); end
        end
        tests_run++;
        if (seg_n !== 7'b0111000 || frame_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL midload_apply got seg=%b fd=%b exp seg=0111000 fd=1", seg_n, frame_done);
        end
        for (int g = 0; g < 4; g++) begin
            set_load({4'(4*g+3), 4'(4*g+2), 4'(4*g+1), 4'(4*g)}, 4'b0000, 4'b0000, 4'd15);
            repeat (2 * FRAME) begin
                drive_cycle();
                e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
                if (got !== e) begin tests_failed++; $display("FAIL glyph%0d cyc=%0d got %b exp %b", g, cyc, got, e); end
            end
        end
    endtask

    task automatic test_boundary_load();
        exp_t e, got;
        set_load(16'h5678, 4'b0000, 4'b0000, 4'd15);
        repeat (FRAME - 1) begin
            drive_cycle();
            e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL edgeload cyc=%0d got %b exp %b", cyc, got, e); end
        end
        set_load(16'h9ABC, 4'b0000, 4'b0000, 4'd15);
        drive_cycle();
        e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL edgeload cyc=%0d got %b exp %b", cyc, got, e); end
        tests_run++;
        if (seg_n !== 7'b0000000) begin tests_failed++; $display("FAIL edgeload_old got %b exp 0000000", seg_n); end
        repeat (FRAME) begin
            drive_cycle();
            e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL edgeload cyc=%0d got %b exp %b", cyc, got, e); end
        end
        tests_run++;
        if (seg_n !== 7'b0110001) begin tests_failed++; $display("FAIL edgeload_new got %b exp 0110001", seg_n); end
    endtask

    task automatic test_blank_reset();
        exp_t e, got;
        set_load(16'h1234, 4'b0010, 4'b0010, 4'd15);
        repeat (FRAME + 2 * SLOT + 10) begin
            drive_cycle();
            e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL blank cyc=%0d got %b exp %b", cyc, got, e); end
        end
        tests_run++;
        if (an_n !== 4'b1011) begin tests_failed++; $display("FAIL prereset_an got %b exp 1011", an_n); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({seg_n, dp_n, an_n, frame_done} !== 13'b1111111_1_1111_0) begin
            tests_failed++;
            $display("FAIL async_reset got %b exp 1111111111110", {seg_n, dp_n, an_n, frame_done});
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (2 * FRAME) begin
            drive_cycle();
            e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL postreset cyc=%0d got %b exp %b", cyc, got, e); end
        end
        set_load(16'h4321, 4'b0000, 4'b1000, 4'd7);
        repeat (2 * FRAME) begin
            drive_cycle();
            e = sbq.pop_front(); got = {seg_n, dp_n, an_n, frame_done}; tests_run++;
            if (got !== e) begin tests_failed++; $display("FAIL reload cyc=%0d got %b exp %b", cyc, got, e); end
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_brightness();
        test_glyphs();
        test_boundary_load();
        test_blank_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed driver for an N-digit common-anode seven-segment display. It is the parametrised successor of the single-digit hex decoder. It holds a double-buffered frame of hex digits, per-digit blank flags, decimal points and a brightness level. It scans one digit at a time and drives active-low segment and anode lines directly to the board pins. It sits between the application's display-value logic and the FPGA display pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..16).
- PHASE_CYCLES, 625, clock cycles per brightness phase; a digit slot lasts 16 phases, 16*PHASE_CYCLES cycles (≥1).
- clk  in  1  system clock; every register updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- digits_in  in  4*NUM_DIGITS  hex value per digit; digit k is bits [4k+3:4k].
- blank_in  in  NUM_DIGITS  1 = digit k is dark (anode and segments off).
- dp_in  in  NUM_DIGITS  1 = decimal point of digit k lit.
- brightness_in  in  4  lit phases per slot, 0 (off) .. 15 (15/16 duty).
- load  in  1  1-cycle strobe; captures all *_in into the shadow frame.
- seg_n  out  7  active-low segments {a,b,c,d,e,f,g}, with a as the MSB.
- dp_n  out  1  active-low decimal point.
- an_n  out  NUM_DIGITS  active-low anode enables; bit k selects digit k.
- frame_done  out  1  1-cycle pulse at the start of each frame.

## Operation
- Counters:
  - phase_cnt counts 0..PHASE_CYCLES-1.
  - phase counts 0..15 and advances when phase_cnt wraps.
  - digit counts 0..NUM_DIGITS-1 and advances when phase wraps from 15.
  - digit wraps to 0 after NUM_DIGITS-1.
- Shadow frame:
  - When load=1, the shadow registers capture digits_in, blank_in, dp_in and brightness_in.
  - load also sets the pending flag.
- Active frame:
  - The frame boundary is the edge where digit wraps from NUM_DIGITS-1 to 0.
  - At the boundary, if pending=1, shadow is copied to active and pending is cleared.
  - If load is also high on that edge, shadow takes the new values, pending remains 1, and the copy happens at the next boundary.
  - The active frame never changes mid-frame (no tearing).
- Glyphs, hex to seg_n:
  - 0 → 0000001, 1 → 1001111, 2 → 0010010, 3 → 0000110
  - 4 → 1001100, 5 → 0100100, 6 → 0100000, 7 → 0001111
  - 8 → 0000000, 9 → 0000100, A → 0001000, b → 1100000
  - C → 0110001, d → 1000010, E → 0110000, F → 0111000
- Output rules for current digit d:
  - seg_n is the glyph of active digit d, or 1111111 if blank[d]=1.
  - dp_n is ~dp[d], forced to 1 if blank[d]=1.
  - an_n[d]=0 only when 1 ≤ phase ≤ active brightness and blank[d]=0.
  - All other an_n bits are always 1.
  - Phase 0 is always dark. This is the ghosting guard: segments change while every anode is off.
- Reset:
  - Counters = 0, pending = 0.
  - Shadow and active frames: digits 0, blank all 1, dp 0, brightness 0.
  - Consequence: the display stays dark until the first load is applied.

## Timing
- All outputs are registered and are updated on the same edge as the counters, so outputs always correspond to the current (digit, phase).
- Reset values: seg_n=1111111, dp_n=1, an_n=all 1, frame_done=0.
- frame_done is high for exactly the first cycle of each frame (digit 0, phase 0, phase_cnt 0). It is not asserted during the first frame after reset.
- Frame period is 16*PHASE_CYCLES*NUM_DIGITS cycles.
- load-to-display latency:
  - A load is visible from the next frame boundary.
  - Worst case is one full frame plus one cycle.
- Lit time per slot is brightness*PHASE_CYCLES cycles, contiguous, starting at phase 1.
- rst_n low mid-frame: all outputs go to reset values immediately (asynchronous). The scan restarts at digit 0 on the first edge after release.
- With NUM_DIGITS=1, every slot end is a frame boundary.
- With PHASE_CYCLES=1, phase advances every cycle.

## Test plan
Bench parameters: NUM_DIGITS=4, PHASE_CYCLES=2 (slot = 32 cycles, frame = 128 cycles).

1. Reset release, no load → an_n=1111, seg_n=1111111, dp_n=1 for 512 cycles. frame_done pulses every 128 cycles, starting at cycle 128.
2. load with digits_in=16'hA321, blank_in=0, dp_in=4'b0100, brightness_in=15:
   - From the next frame_done, slot k shows glyphs 1, 2, 3, A.
   - Each slot has 2 dark cycles, then 30 cycles with an_n[k]=0.
   - dp_n=0 only in slot 2.
3. brightness_in=3 → each slot has exactly 6 lit cycles, starting at cycle offset 2. brightness_in=0 → an_n stays 1111 throughout.
4. Change load mid-frame (digits_in=16'hFFFF) → the current frame still shows the old values. The new values appear exactly at the next frame_done. Every hex value 0..F is checked against the glyph list.
5. load asserted on the boundary edge → the old shadow is applied now, and the new values are applied at the following boundary.
6. blank_in=4'b0010, dp_in=4'b0010 → slot 1 keeps an_n=1111, seg_n=1111111, dp_n=1. rst_n pulsed low mid-slot 2 → outputs go to reset values immediately. After release the scan restarts at digit 0 with the display dark until the next load.
